// File: rtl/bus_dram_responder_pkg.sv
// Shared bus types and DRAM responder definitions.
// bus_t and sel_t are the system bus payload and target select; the
// responder adds its FSM state type and default wait-state count.
package bus_dram_responder_pkg;

  typedef enum logic [1:0] {
    NOSEL = 2'd0,
    DRAM  = 2'd1,
    UART  = 2'd2,
    GPIO  = 2'd3
  } sel_t;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] address;
    sel_t        sel;
  } bus_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dram_state_t;

  localparam int DRAM_WAIT_DEFAULT = 2;

endpackage

// File: rtl/dram_mem_sp.sv
// Single-port synchronous RAM, 16-bit words, registered read data.
// Written in the plain inferable form so it maps onto M9K blocks;
// contents have no reset.
module dram_mem_sp #(
  parameter  int DEPTH     = 4096,
  localparam int ADDR_BITS = $clog2(DEPTH),
  localparam int WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_dram_responder.sv
// DRAM target endpoint on the shared system bus.
// Accepts one request at a time when sel == DRAM, inserts WAIT_CYCLES
// wait states, performs a one-cycle RAM access and answers with a
// one-cycle ack pulse (read data in rdata while ack is high).
// Optional build macro DRAM_RANGE_CHECK_EN adds an err output that flags
// addresses at or above DEPTH instead of letting them alias.
module bus_dram_responder
  import bus_dram_responder_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = DRAM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  bus_t        bus_in,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        busy
`ifdef DRAM_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  dram_state_t          state;
  logic [7:0]           cnt;
  logic                 accept;
  logic                 oor_in;

  // Transaction captured at the accepting edge
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [15:0]          wdata_q;
  logic                 oor_q;

  // RAM interface
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_q;

  assign accept = (state == IDLE) && req && (bus_in.sel == DRAM);

`ifdef DRAM_RANGE_CHECK_EN
  // Full 16-bit address compared against DEPTH; 17 bits so DEPTH = 65536 fits.
  assign oor_in = ({1'b0, bus_in.address} >= 17'(DEPTH));
`else
  // Upper address bits are deliberately dropped so addresses alias.
  logic unused_addr;
  assign unused_addr = ^bus_in.address;
  assign oor_in      = 1'b0;
`endif

  // While idle the RAM reads the live bus address so that, even with no
  // wait states, its registered output already holds the word when the
  // FSM reaches ACCESS; afterwards it keeps reading the latched address.
  assign mem_addr = (state == IDLE) ? bus_in.address[ADDR_BITS-1:0] : addr_q;
  assign mem_we   = (state == ACCESS) && we_q && !oor_q;

  dram_mem_sp #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_q)
  );

  // Capture the request payload on the accepting edge; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= bus_in.address[ADDR_BITS-1:0];
      wdata_q <= bus_in.data;
      oor_q   <= oor_in;
    end
  end

  // Control FSM with registered ack/busy/rdata (and err when range checking is built in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      rdata <= 16'h0000;
`ifdef DRAM_RANGE_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef DRAM_RANGE_CHECK_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 8'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACCESS: begin
          state <= RESP;
          ack   <= 1'b1;
`ifdef DRAM_RANGE_CHECK_EN
          err   <= oor_q;
`endif
          if (!we_q) begin
            rdata <= oor_q ? 16'h0000 : mem_q;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dram_responder.sv
// Scoreboard bench for bus_dram_responder: one instance with two wait
// states, one with none. The driver pushes the expected ack cycle, rdata
// and err for each accepted request; per-instance monitors pop and compare
// whenever ack is high.
module tb_bus_dram_responder;
  import bus_dram_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req2, we2, ack2, busy2;
  bus_t        bus2;
  logic [15:0] rdata2;
  logic        req0, we0, ack0, busy0;
  bus_t        bus0;
  logic [15:0] rdata0;
`ifdef DRAM_RANGE_CHECK_EN
  logic        err2, err0;
`endif

  bus_dram_responder #(.DEPTH(4096), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .we(we2), .bus_in(bus2),
    .ack(ack2), .rdata(rdata2), .busy(busy2)
`ifdef DRAM_RANGE_CHECK_EN
    , .err(err2)
`endif
  );

  bus_dram_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .bus_in(bus0),
    .ack(ack0), .rdata(rdata0), .busy(busy0)
`ifdef DRAM_RANGE_CHECK_EN
    , .err(err0)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] rdata;
    int          due;
    logic        err;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  exp_t        m2e, m0e;
  logic [15:0] last2, last0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the two-wait-state instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_ack2", 32'(ack2), 32'd0);
      end else begin
        m2e = q2.pop_front();
        chk("latency2", cyc, m2e.due);
        chk("rdata2", 32'(rdata2), 32'(m2e.rdata));
`ifdef DRAM_RANGE_CHECK_EN
        chk("err2", 32'(err2), 32'(m2e.err));
`endif
      end
    end
  end

  // Monitor for the zero-wait-state instance
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("unexpected_ack0", 32'(ack0), 32'd0);
      end else begin
        m0e = q0.pop_front();
        chk("latency0", cyc, m0e.due);
        chk("rdata0", 32'(rdata0), 32'(m0e.rdata));
`ifdef DRAM_RANGE_CHECK_EN
        chk("err0", 32'(err0), 32'(m0e.err));
`endif
      end
    end
  end

  // Issue one transaction starting at the current negedge; returns at the
  // negedge of the idle cycle after ack, ready to issue the next one.
  task automatic txn(input int inst, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] rd, input logic e_err);
    exp_t e;
    logic got;
    if (inst == 2) begin
      req2 = 1'b1; we2 = w; bus2.data = d; bus2.address = a; bus2.sel = DRAM;
    end else begin
      req0 = 1'b1; we0 = w; bus0.data = d; bus0.address = a; bus0.sel = DRAM;
    end
    @(negedge clk);
    e.err = e_err;
    if (inst == 2) begin
      if (!w) last2 = rd;
      e.rdata = last2;
      e.due   = cyc + 2 + 1;
      q2.push_back(e);
      req2 = 1'b0; we2 = ~w; bus2.data = ~d; bus2.address = ~a;
      chk("busy2_after_accept", 32'(busy2), 32'd1);
    end else begin
      if (!w) last0 = rd;
      e.rdata = last0;
      e.due   = cyc + 0 + 1;
      q0.push_back(e);
      req0 = 1'b0; we0 = ~w; bus0.data = ~d; bus0.address = ~a;
      chk("busy0_after_accept", 32'(busy0), 32'd1);
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((inst == 2 ? ack2 : ack0) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (got && inst == 2) chk("busy2_in_ack", 32'(busy2), 32'd1);
    @(negedge clk);
    chk("busy_after_ack", 32'(inst == 2 ? busy2 : busy0), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req2 = 1'b0; we2 = 1'b0; bus2 = '{data: 16'h0, address: 16'h0, sel: NOSEL};
    req0 = 1'b0; we0 = 1'b0; bus0 = '{data: 16'h0, address: 16'h0, sel: NOSEL};
    last2 = 16'h0; last0 = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_ack2", 32'(ack2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_rdata2", 32'(rdata2), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy2", 32'(busy2), 32'd0);
    chk("idle_ack2", 32'(ack2), 32'd0);

    // Write then read with two wait states
    txn(2, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    txn(2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // Request to another target must be ignored
    req2 = 1'b1; we2 = 1'b1; bus2.data = 16'hDEAD; bus2.address = 16'h0010; bus2.sel = UART;
    repeat (5) begin
      @(negedge clk);
      chk("wrongsel_busy2", 32'(busy2), 32'd0);
      chk("wrongsel_ack2", 32'(ack2), 32'd0);
    end
    req2 = 1'b0; bus2.sel = DRAM;
    @(negedge clk);
    txn(2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

    // Back-to-back transactions with no wait states
    txn(0, 1'b1, 16'h0001, 16'h1111, 16'h0000, 1'b0);
    txn(0, 1'b1, 16'h0002, 16'h2222, 16'h0000, 1'b0);
    txn(0, 1'b0, 16'h0001, 16'h0000, 16'h1111, 1'b0);
    txn(0, 1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b0);

    // Address aliasing / range check
    txn(2, 1'b1, 16'h0003, 16'h0F0F, 16'h0000, 1'b0);
`ifdef DRAM_RANGE_CHECK_EN
    txn(2, 1'b1, 16'h1003, 16'hA5A5, 16'h0000, 1'b1);
    txn(2, 1'b0, 16'h0003, 16'h0000, 16'h0F0F, 1'b0);
`else
    txn(2, 1'b1, 16'h1003, 16'hA5A5, 16'h0000, 1'b0);
    txn(2, 1'b0, 16'h0003, 16'h0000, 16'hA5A5, 1'b0);
`endif

    // Reset during the wait states drops the pending write
    txn(2, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0);
    req2 = 1'b1; we2 = 1'b1; bus2.data = 16'h5555; bus2.address = 16'h0020; bus2.sel = DRAM;
    @(negedge clk);
    req2 = 1'b0;
    chk("busy2_in_wait", 32'(busy2), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack2", 32'(ack2), 32'd0);
    chk("midrst_busy2", 32'(busy2), 32'd0);
    chk("midrst_rdata2", 32'(rdata2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last2 = 16'h0; last0 = 16'h0;
    repeat (8) begin
      @(negedge clk);
      chk("postrst_ack2", 32'(ack2), 32'd0);
    end
    txn(2, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);

    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", total);
    $fatal(1);
  end

endmodule
